// File: rtl/aes_rr_scheduler.sv
// aes_rr_scheduler: round-robin scheduler sharing one AES core between N_REQ requesters, with a watchdog timeout
// Ports: clk, srst (sync, active high); req/req_mode/req_key/req_word are per-requester inputs (packed slices);
// gnt and rsp_valid are one-hot single-cycle pulses; rsp_result/rsp_err hold the last response;
// busy is high outside IDLE; aes_enable/aes_mode/aes_key/aes_word drive the core, aes_result/aes_done come back.
module aes_rr_scheduler #(
  parameter int N_REQ      = 4,
  parameter int KEY_BW     = 256,
  parameter int WORD_BW    = 128,
  parameter int TIMEOUT    = 64,
  parameter int GAP_CYCLES = 2
) (
  input  logic                       clk,
  input  logic                       srst,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ-1:0]           req_mode,
  input  logic [N_REQ*KEY_BW-1:0]    req_key,
  input  logic [N_REQ*WORD_BW-1:0]   req_word,
  output logic [N_REQ-1:0]           gnt,
  output logic [N_REQ-1:0]           rsp_valid,
  output logic [WORD_BW-1:0]         rsp_result,
  output logic                       rsp_err,
  output logic                       busy,
  output logic                       aes_enable,
  output logic                       aes_mode,
  output logic [KEY_BW-1:0]          aes_key,
  output logic [WORD_BW-1:0]         aes_word,
  input  logic [WORD_BW-1:0]         aes_result,
  input  logic                       aes_done
);
  localparam int PW = $clog2(N_REQ);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, RUN, RESP, GAP} state_t;
  state_t state, state_n;
  logic [PW-1:0] ptr, owner, pick, idx;
  logic [CW-1:0] cnt;
  logic [GW-1:0] gap;
  logic limit, finish;
  logic [KEY_BW-1:0] keys [N_REQ];
  logic [WORD_BW-1:0] words [N_REQ];
  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign keys[i] = req_key[i*KEY_BW +: KEY_BW];
    assign words[i] = req_word[i*WORD_BW +: WORD_BW];
  end
  // scan downward so the requester closest above ptr (with wrap) is the last, winning assignment
  always_comb begin
    pick = '0;
    idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = PW'((int'(ptr) + i) % N_REQ);
      if (req[idx]) pick = idx;
    end
  end
  assign limit = cnt == CW'(TIMEOUT - 1);
  assign finish = aes_done || limit;
  assign busy = state != IDLE;
  always_ff @(posedge clk) state <= srst ? IDLE : state_n;
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? (|req ? RUN : IDLE) :
              state == RUN  ? (finish ? RESP : RUN) :
              state == RESP ? GAP :
              (gap == GW'(GAP_CYCLES - 1) ? IDLE : GAP);
  end
  always_ff @(posedge clk) begin
    if (srst) begin
      ptr <= '0;
      owner <= '0;
      cnt <= '0;
      gap <= '0;
      gnt <= '0;
      rsp_valid <= '0;
      rsp_result <= '0;
      rsp_err <= 1'b0;
      aes_enable <= 1'b0;
      aes_mode <= 1'b0;
      aes_key <= '0;
      aes_word <= '0;
    end else begin
      gnt <= '0;
      rsp_valid <= '0;
      gap <= state == GAP ? gap + 1'b1 : '0;
      if (state == IDLE && |req) begin
        aes_mode <= req_mode[pick];
        aes_key <= keys[pick];
        aes_word <= words[pick];
        owner <= pick;
        ptr <= pick == PW'(N_REQ - 1) ? '0 : pick + 1'b1;
        cnt <= '0;
        gnt <= N_REQ'(1) << pick;
        aes_enable <= 1'b1;
      end
      if (state == RUN) begin
        cnt <= cnt + 1'b1;
        if (finish) begin
          // done has priority over the watchdog when both land on the same edge
          rsp_result <= aes_done ? aes_result : '0;
          rsp_err <= !aes_done;
          rsp_valid <= N_REQ'(1) << owner;
          aes_enable <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_aes_rr_scheduler.sv
// tb_aes_rr_scheduler: randomized and directed self-checking bench with a job-level reference model
module tb_aes_rr_scheduler;
  localparam int N = 4;
  localparam int KB = 256;
  localparam int WB = 128;
  localparam int TO = 64;
  localparam int G = 2;
  localparam logic [255:0] FKEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT = 128'h8ea2b7ca516745bfeafc49904b496089;
  logic clk = 1'b0;
  logic srst;
  logic [N-1:0] req, req_mode, gnt, rsp_valid;
  logic [N*KB-1:0] req_key;
  logic [N*WB-1:0] req_word;
  logic [WB-1:0] rsp_result, aes_word, aes_result;
  logic rsp_err, busy, aes_enable, aes_mode;
  logic aes_done = 1'b0;
  logic [KB-1:0] aes_key;
  int checks = 0;
  int errors = 0;
  int drv_mode = 0;
  int lat = 2;
  int en_cnt = 0;
  bit chk_on = 0;
  int gq[$];
  always #5 clk = ~clk;
  aes_rr_scheduler #(.N_REQ(N), .KEY_BW(KB), .WORD_BW(WB), .TIMEOUT(TO), .GAP_CYCLES(G)) dut (
    .clk(clk), .srst(srst), .req(req), .req_mode(req_mode), .req_key(req_key), .req_word(req_word),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_result(rsp_result), .rsp_err(rsp_err), .busy(busy),
    .aes_enable(aes_enable), .aes_mode(aes_mode), .aes_key(aes_key), .aes_word(aes_word),
    .aes_result(aes_result), .aes_done(aes_done)
  );
  // stand-in core: known FIPS-197 AES-256 vectors, otherwise a cheap reversible mix
  function automatic logic [127:0] core_fn(input logic m, input logic [255:0] k, input logic [127:0] w);
    if (k == FKEY && !m && w == PT) return CT;
    if (k == FKEY && m && w == CT) return PT;
    return w ^ k[127:0] ^ k[255:128] ^ {128{m}};
  endfunction
  // done after lat enabled cycles (lat 0 = never); spurious done strobes while the core is idle
  always @(negedge clk) begin
    en_cnt = aes_enable ? en_cnt + 1 : 0;
    aes_done = aes_enable ? (lat != 0 && en_cnt == lat) : ($urandom_range(0, 7) == 0);
    aes_result = (aes_done && aes_enable) ? core_fn(aes_mode, aes_key, aes_word) : {$urandom, $urandom, $urandom, $urandom};
  end
  // job-level reference: a job ages from its grant; it ends on done or at age TIMEOUT,
  // then the scheduler is unavailable for the response cycle plus G gap cycles
  logic [N-1:0] e_gnt, e_rv;
  logic [WB-1:0] e_res, e_word;
  logic [KB-1:0] e_key;
  logic e_err, e_busy, e_en, e_mode;
  bit act;
  int age, gap_left, m_ptr, m_own;
  always @(posedge clk) begin
    e_gnt = '0;
    e_rv = '0;
    if (srst) begin
      act = 0; gap_left = 0; m_ptr = 0; m_own = 0;
      e_en = 0; e_mode = 0; e_key = '0; e_word = '0; e_res = '0; e_err = 0;
    end else if (act) begin
      age++;
      if (aes_done || age == TO) begin
        e_res = aes_done ? aes_result : '0;
        e_err = !aes_done;
        e_rv[m_own] = 1'b1;
        e_en = 0;
        act = 0;
        gap_left = G + 1;
      end
    end else if (gap_left > 0) begin
      gap_left--;
    end else if (req != 0) begin
      for (int i = 0; i < N; i++) if (req[(m_ptr + i) % N]) begin m_own = (m_ptr + i) % N; break; end
      m_ptr = (m_own + 1) % N;
      age = 0;
      act = 1;
      e_gnt[m_own] = 1'b1;
      e_en = 1;
      e_mode = req_mode[m_own];
      e_key = req_key[m_own*KB +: KB];
      e_word = req_word[m_own*WB +: WB];
    end
    e_busy = act || gap_left > 0;
  end
  task automatic chk(input string name, input logic [383:0] act_v, input logic [383:0] exp_v);
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act_v, exp_v);
    end
  endtask
  task automatic raise(input int i, input logic m, input logic [255:0] k, input logic [127:0] w);
    req[i] = 1'b1;
    req_mode[i] = m;
    req_key[i*KB +: KB] = k;
    req_word[i*WB +: WB] = w;
  endtask
  task automatic tick();
    @(negedge clk);
    if (chk_on) begin
      chk("gnt", gnt, e_gnt);
      chk("rsp_valid", rsp_valid, e_rv);
      chk("rsp_err_result", {rsp_err, rsp_result}, {e_err, e_res});
      chk("busy", busy, e_busy);
      chk("aes_enable_mode", {aes_enable, aes_mode}, {e_en, e_mode});
      chk("aes_key", aes_key, e_key);
      chk("aes_word", aes_word, e_word);
    end
    for (int i = 0; i < N; i++) begin
      if (gnt[i]) gq.push_back(i);
      if (req[i] && gnt[i]) req[i] = 1'b0;
      else if (!req[i] && ((drv_mode == 2 && rsp_valid[i]) || (drv_mode == 1 && $urandom_range(0, 5) == 0)))
        raise(i, 1'($urandom_range(0, 1)), {8{$urandom}}, {4{$urandom}});
    end
    if (drv_mode == 1) begin
      if (!aes_enable) lat = $urandom_range(0, 15) == 0 ? 0 : $urandom_range(0, 7) == 0 ? 63 + $urandom_range(0, 2) : $urandom_range(1, 6);
      if (srst) srst = 1'b0;
      else if ($urandom_range(0, 799) == 0) srst = 1'b1;
    end
  endtask
  task automatic wait_rsp(output int n);
    n = 0;
    while (rsp_valid == 0 && n < 300) begin tick(); n++; end
    chk("rsp_arrived", rsp_valid != 0, 1'b1);
  endtask
  task automatic wait_idle();
    int n = 0;
    while ((busy || req != 0) && n < 600) begin tick(); n++; end
    chk("reached_idle", busy, 1'b0);
  endtask
  initial begin
    int n;
    srst = 1'b1; req = '0; req_mode = '0; req_key = '0; req_word = '0;
    tick();
    chk_on = 1;
    tick();
    chk("reset_busy", busy, 1'b0);
    chk("reset_gnt", gnt, 4'b0000);
    chk("reset_enable", aes_enable, 1'b0);
    chk("reset_err", rsp_err, 1'b0);
    srst = 1'b0;
    tick();
    // FIPS-197 encrypt through requester 2
    raise(2, 1'b0, FKEY, PT);
    tick();
    chk("enc_gnt", gnt, 4'b0100);
    wait_rsp(n);
    chk("enc_valid", rsp_valid, 4'b0100);
    chk("enc_result", rsp_result, CT);
    chk("enc_err", rsp_err, 1'b0);
    wait_idle();
    // decrypt round trip through requester 1
    raise(1, 1'b1, FKEY, CT);
    tick();
    chk("dec_gnt", gnt, 4'b0010);
    wait_rsp(n);
    chk("dec_valid", rsp_valid, 4'b0010);
    chk("dec_result", rsp_result, PT);
    wait_idle();
    // watchdog: core never completes
    lat = 0;
    raise(0, 1'b0, {8{32'h1234_5678}}, {4{32'hcafe_f00d}});
    tick();
    chk("to_gnt", gnt, 4'b0001);
    wait_rsp(n);
    chk("to_latency", n, 64);
    chk("to_valid", rsp_valid, 4'b0001);
    chk("to_err", rsp_err, 1'b1);
    chk("to_result", rsp_result, 128'h0);
    for (int j = 0; j < 3; j++) begin
      tick();
      chk("to_gap_enable", aes_enable, 1'b0);
      chk("to_gap_busy", busy, j < 2);
    end
    // done exactly on the last allowed cycle wins over the timeout
    lat = 64;
    raise(3, 1'b1, {8{32'h0bad_beef}}, {4{32'h5555_aaaa}});
    tick();
    chk("lim_gnt", gnt, 4'b1000);
    wait_rsp(n);
    chk("lim_latency", n, 64);
    chk("lim_err", rsp_err, 1'b0);
    chk("lim_result", rsp_result, {4{32'h5555_aaaa}} ^ {4{32'h0bad_beef}} ^ {4{32'h0bad_beef}} ^ {128{1'b1}});
    wait_idle();
    // reset mid-RUN, then ptr must be back at 0
    lat = 0;
    raise(2, 1'b0, FKEY, PT);
    tick();
    chk("rst_job_gnt", gnt, 4'b0100);
    repeat (10) tick();
    srst = 1'b1;
    tick();
    srst = 1'b0;
    lat = 3;
    chk("rst_busy", busy, 1'b0);
    chk("rst_enable", aes_enable, 1'b0);
    chk("rst_key", aes_key, 256'h0);
    chk("rst_result", rsp_result, 128'h0);
    for (int j = 0; j < 6; j++) begin
      tick();
      chk("rst_no_rsp", rsp_valid, 4'b0000);
    end
    raise(1, 1'b0, FKEY, PT);
    raise(3, 1'b1, FKEY, CT);
    tick();
    chk("rst_first_gnt", gnt, 4'b0010);
    wait_rsp(n);
    n = 0;
    while (gnt == 0 && n < 50) begin tick(); n++; end
    chk("rst_second_gnt", gnt, 4'b1000);
    wait_idle();
    // fairness: everyone re-raises after its response
    gq.delete();
    lat = 2;
    drv_mode = 2;
    for (int i = 0; i < N; i++) raise(i, 1'b0, {8{$urandom}}, {4{$urandom}});
    n = 0;
    while (gq.size() < 8 && n < 500) begin tick(); n++; end
    drv_mode = 0;
    chk("fair_count", gq.size() >= 8, 1'b1);
    for (int j = 0; j < 8 && j < gq.size(); j++) chk("fair_order", gq[j], j % N);
    wait_idle();
    // randomized traffic, latencies, spurious done and occasional reset
    drv_mode = 1;
    repeat (4000) tick();
    drv_mode = 0;
    srst = 1'b0;
    lat = 2;
    wait_idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/aes_rr_scheduler.md
Name: aes_rr_scheduler

Overview:
- Round-robin scheduler that shares one AES core (enable/mode/key/word in, result/done out) between N_REQ requesters.
- Each requester asks for a single-block encrypt or decrypt. The scheduler grants one requester at a time, latches its operands, drives the core, then returns the result to that requester.
- A watchdog returns an error if the core never signals done.
- Sits between the signature-authenticator request clients and the AES core.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- KEY_BW, 256, key width.
- WORD_BW, 128, data block width.
- TIMEOUT, 64, max RUN cycles before abort (>=2).
- GAP_CYCLES, 2, cycles aes_enable is held low between jobs (>=1).

Ports:
- clk  in  1  clock, rising edge.
- srst  in  1  synchronous reset, active high.
- req  in  N_REQ  per-requester request level.
- req_mode  in  N_REQ  per-requester mode; 0 = encrypt, 1 = decrypt.
- req_key  in  N_REQ*KEY_BW  packed keys; requester i uses slice [i*KEY_BW +: KEY_BW].
- req_word  in  N_REQ*WORD_BW  packed blocks, same slicing rule.
- gnt  out  N_REQ  one-hot, one-cycle accept pulse.
- rsp_valid  out  N_REQ  one-hot, one-cycle response pulse.
- rsp_result  out  WORD_BW  result; valid only while rsp_valid is nonzero.
- rsp_err  out  1  timeout flag, qualified by rsp_valid.
- busy  out  1  high in every state except IDLE.
- aes_enable  out  1  core enable (level).
- aes_mode  out  1  core mode.
- aes_key  out  KEY_BW  core key.
- aes_word  out  WORD_BW  core input block.
- aes_result  in  WORD_BW  core output block.
- aes_done  in  1  core completion strobe.

Behaviour:
- All outputs are registered except busy, which is decoded from state.
- Reset: every output is 0, state = IDLE, round-robin pointer = 0 (requester 0 highest priority), owner = 0, cycle counter = 0.
- Reset asserted mid-job aborts the job immediately. No rsp_valid is issued for the aborted job.

State IDLE:
- If req is nonzero at edge t, pick the first set bit searching upward from ptr with wrap-around.
- At edge t, latch that requester's mode, key and word into aes_mode, aes_key and aes_word.
- Also at edge t: set owner = k, set ptr = (k+1) mod N_REQ, clear the counter, go to RUN.
- From t+1: gnt[k] = 1 for exactly one cycle and aes_enable = 1.
- If req is zero, stay in IDLE; ptr is unchanged.

State RUN:
- aes_enable stays 1; aes_mode, aes_key and aes_word are held stable; the counter increments each cycle.
- aes_done = 1: capture aes_result into rsp_result, set rsp_err = 0, go to RESP.
- Otherwise, if counter == TIMEOUT-1: set rsp_result = 0, rsp_err = 1, go to RESP.
- If aes_done and the timeout limit occur in the same cycle, done wins (rsp_err = 0).
- All changes on req are ignored.

State RESP (one cycle):
- rsp_valid[owner] = 1; aes_enable = 0. Go to GAP.

State GAP:
- aes_enable = 0 for GAP_CYCLES cycles, counted from the RESP edge.
- rsp_valid returns to 0.
- rsp_result and rsp_err hold until the next RESP.
- Then go to IDLE.
- aes_done is ignored in RESP, GAP and IDLE.

Requester protocol and latency:
- A requester holds req and its operands stable until it sees gnt. Operands are sampled on the edge where req is seen in IDLE.
- A requester deasserts req on the cycle after gnt. If req is still high when the scheduler is next in IDLE, it is treated as a new request.
- Per job, aes_done sampled at edge d gives rsp_valid at cycle d+1.
- Minimum spacing between successive grants is 2 + core latency + GAP_CYCLES.
- Simultaneous requests are served in strict rotation. With all N_REQ requesting continuously, each is served once per N_REQ jobs (no starvation).
- Width rules:
  - ptr and owner are clog2(N_REQ) bits.
  - The counter is clog2(TIMEOUT+1) bits.
  - Index arithmetic wraps modulo N_REQ, including non-power-of-two N_REQ.

Test Plan:
- Single request, rsp_err: req = 4'b0100, mode = 0, FIPS-197 AES-256 key 000102..1f, word 00112233..eeff. Expect gnt = 4'b0100 one cycle after req, rsp_valid = 4'b0100, rsp_result = 8ea2b7ca516745bfeafc49904b496089, rsp_err = 0.
- Decrypt round-trip: req[1] with mode = 1, same key, word 8ea2b7ca..6089. Expect rsp_result = 00112233445566778899aabbccddeeff on rsp_valid[1].
- Fairness: req = 4'b1111 held, each requester re-raising req after its response, 8 jobs. Expect grant order 0,1,2,3,0,1,2,3 and each rsp_valid bit matching its grant.
- Timeout: core model never asserts done, TIMEOUT = 64. Expect rsp_valid[owner] at RUN cycle 65, rsp_err = 1, rsp_result = 0, aes_enable low for GAP_CYCLES, then IDLE.
- Done at the limit: aes_done raised on counter == TIMEOUT-1. Expect rsp_err = 0 and the captured result returned.
- Reset mid-RUN: srst pulsed for 1 cycle during RUN. Expect all outputs 0 the next cycle, no rsp_valid, and a subsequent req = 4'b1010 granted to requester 1 first (ptr reset to 0).
